// File: rtl/fb_blit_engine.sv
`default_nettype none
// ============================================================================
// fb_blit_engine : text-mode frame buffer clear / scroll-up bus initiator
// Revision       : 1.0
// ============================================================================
module fb_blit_engine #(
    parameter logic [18:0] BASE_ADDR = 19'h5C000,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] fill_word,
    output logic        busy,
    output logic        done,
    output logic        data_m_access,
    input  logic        data_m_ack,
    output logic [18:0] data_m_addr,
    output logic        data_m_wr_en,
    output logic [15:0] data_m_data_out,
    input  logic [15:0] data_m_data_in,
    output logic [1:0]  data_m_bytesel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [10:0] LAST_COPY = 11'((ROWS - 1) * COLS - 1);
    localparam logic [10:0] LAST_FILL = 11'(ROWS * COLS - 1);
    localparam logic [18:0] ROW_STEP  = 19'(COLS);

    state_t      state_q,   state_d;
    logic [10:0] index_q,   index_d;
    logic [15:0] fill_q,    fill_d;
    logic [15:0] copy_q,    copy_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        access_q,  access_d;
    logic        wr_en_q,   wr_en_d;
    logic [18:0] addr_q,    addr_d;
    logic [15:0] data_q,    data_d;
    logic [1:0]  bytesel_q, bytesel_d;
    logic [18:0] cell_addr;
    logic        accepted;

    assign cell_addr = BASE_ADDR + {8'd0, index_q};
    // Ack only counts while our own request is up; a trailing ack is dropped.
    assign accepted  = access_q && data_m_ack;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        fill_d    = fill_q;
        copy_d    = copy_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        access_d  = access_q;
        wr_en_d   = wr_en_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bytesel_d = bytesel_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fill_d  = fill_word;
                    index_d = 11'd0;
                    busy_d  = 1'b1;
                    state_d = op ? S_READ : S_FILL;
                end
            end
            S_READ: begin
                if (!access_q) begin
                    access_d  = 1'b1;
                    wr_en_d   = 1'b0;
                    addr_d    = cell_addr + ROW_STEP;
                    bytesel_d = 2'b11;
                end else if (accepted) begin
                    access_d  = 1'b0;
                    bytesel_d = 2'b00;
                    copy_d    = data_m_data_in;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!access_q) begin
                    access_d  = 1'b1;
                    wr_en_d   = 1'b1;
                    addr_d    = cell_addr;
                    data_d    = copy_q;
                    bytesel_d = 2'b11;
                end else if (accepted) begin
                    access_d  = 1'b0;
                    bytesel_d = 2'b00;
                    index_d   = index_q + 11'd1;
                    state_d   = (index_q == LAST_COPY) ? S_FILL : S_READ;
                end
            end
            S_FILL: begin
                if (!access_q) begin
                    access_d  = 1'b1;
                    wr_en_d   = 1'b1;
                    addr_d    = cell_addr;
                    data_d    = fill_q;
                    bytesel_d = 2'b11;
                end else if (accepted) begin
                    access_d  = 1'b0;
                    bytesel_d = 2'b00;
                    index_d   = index_q + 11'd1;
                    if (index_q == LAST_FILL) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // First cycle raises done; second drops busy and returns to idle.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            index_q   <= 11'd0;
            fill_q    <= 16'd0;
            copy_q    <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            access_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= 19'd0;
            data_q    <= 16'd0;
            bytesel_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            fill_q    <= fill_d;
            copy_q    <= copy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            access_q  <= access_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bytesel_q <= bytesel_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign data_m_access   = access_q;
    assign data_m_wr_en    = wr_en_q;
    assign data_m_addr     = addr_q;
    assign data_m_data_out = data_q;
    assign data_m_bytesel  = bytesel_q;

endmodule
`default_nettype wire
